regs_multiport: RTL and testbench
=================================

Name: regs_multiport

Overview:
- Parametrised successor to the CPU integer register file: XLEN-wide, NREGS-deep, NREAD asynchronous read ports, one synchronous write port.
- Register 0 is hardwired to zero.
- Contains a clear sequencer that zeroes the array after reset or on request, so the array can stay in distributed RAM, which has no reset.
- Sits between the decode stage (read addresses) and the writeback stage (write port).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, 2..256.
- NREAD, 2, number of read ports; 1..4.
- AW, $clog2(NREGS), address width; derived, do not override.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_clr  input  1  request a full array clear; sampled in RUN only.
- i_we  input  1  write enable.
- i_addr_wr  input  AW  write address.
- i_dat_wr  input  XLEN  write data.
- i_addr_rd  input  NREAD*AW  read addresses; port k occupies bits [k*AW +: AW].
- o_dat_rd  output  NREAD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- o_ready  output  1  high in RUN; low while clearing.

Behaviour:
- FSM states: CLEAR, RUN.
- Reset asserted: state goes to CLEAR, clear counter to 1, o_ready to 0. The array contents are not reset.
- CLEAR:
  - Each cycle writes zero to array[counter], then increments the counter.
  - When counter == NREGS-1 the state goes to RUN on that same edge.
  - A clear therefore takes NREGS-1 cycles; o_ready rises on the following edge.
- CLEAR side effects:
  - i_we and i_clr are ignored.
  - All o_dat_rd ports output zero.
- RUN, write: with i_we=1 and i_addr_wr!=0, array[i_addr_wr] takes i_dat_wr at the rising edge.
- RUN, x0 write: writes to address 0 are dropped.
- RUN, clear request: i_clr=1 moves the state to CLEAR with counter=1 on the next edge.
- RUN, simultaneous i_clr and i_we: the clear wins and the write is dropped.
- Reads:
  - Combinational, with zero-cycle latency.
  - o_dat_rd[k] = 0 if the port's address is 0, otherwise array[addr].
  - All ports are independent; any ports may read the same address.
- Reset in the middle of CLEAR or RUN: the clear restarts from counter=1 and any partial clear is simply redone.
- Counter width is AW; no wrap-around is reachable, because CLEAR exits at NREGS-1.
- Width rules: no sign extension or truncation; data passes through at XLEN.

Optional Feature:
- Macro: REGS_MULTIPORT_BYPASS_EN.
- Defined:
  - In RUN, when i_we=1, i_addr_wr!=0 and i_addr_wr equals a read port's address, that port outputs i_dat_wr combinationally in the same cycle (write-through forwarding).
  - The port returns to array data once the write has landed.
  - Address 0 is never bypassed.
- Undefined:
  - Reads return the old array value during a same-cycle write.
  - The new value is visible from the cycle after the edge, and the pipeline handles forwarding.

Decomposition:
- Shared package (cpu_pkg):
  - localparam XLEN_DEFAULT=32.
  - Register-index constant REG_ZERO=0.
  - FSM state encoding typedef regs_state_t {CLEAR, RUN}.
- One natural sub-module: regs_clear_seq, holding the FSM, counter and o_ready and producing the clear write strobe and address.
- Top level: muxes the clear write against the normal write, and generates the NREAD read ports with a generate loop.

Test Plan (all with XLEN=32, NREGS=32, NREAD=2):
- Reset release: pulse i_rst_n low for 2 cycles, then release -> o_ready=0 for exactly 31 cycles, then 1; reading any address returns 0x00000000.
- Write/read sweep: write 0x00550055|i to address i for i=1..31, then read ports a=i, b=i-1 -> a=0x00550055|i, b=0x00550055|(i-1), with b=0 when i-1=0.
- x0 protection: write 0xDEADBEEF to address 0 -> both ports reading address 0 return 0x00000000.
- Clear priority: in RUN, assert i_clr with i_we=1, address 5, data 0x12345678 -> o_ready=0 next cycle; after 31 cycles address 5 reads 0x00000000.
- Reset mid-clear: assert i_rst_n=0 at clear cycle 10 -> the clear restarts; o_ready rises 31 cycles after release, not 21.
- Bypass: write 0xA5A5A5A5 to address 7 with port a reading address 7 -> a shows 0xA5A5A5A5 in the same cycle when REGS_MULTIPORT_BYPASS_EN is defined, and the old value when it is undefined.

Source files
------------

// File: rtl/regs_multiport_pkg.sv
// Shared definitions for the multiport integer register file: default width,
// the hardwired-zero register index and the clear-sequencer state encoding.
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ZERO     = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regs_state_t;

endpackage

// File: rtl/regs_multiport_clear_seq.sv
// Clear sequencer: walks registers 1..NREGS-1 after reset or on request,
// producing a zero-write strobe and address; o_ready is high only in RUN.
module regs_clear_seq
  import cpu_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  output logic          o_ready,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr
);

  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

  regs_state_t   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_IDX) state_d = RUN;
        else                   cnt_d   = cnt_q + AW'(1);
      end
      RUN: begin
        if (i_clr) begin
          state_d = CLEAR;
          cnt_d   = FIRST_IDX;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    o_ready    = (state_q == RUN);
    o_clr_we   = (state_q == CLEAR);
    o_clr_addr = cnt_q;
  end

endmodule

// File: rtl/regs_multiport.sv
// Multiport integer register file: NREAD async read ports, one sync write port,
// x0 hardwired to zero. Define REGS_MULTIPORT_BYPASS_EN for write-through reads.
module regs_multiport
  import cpu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr_wr,
  input  logic [XLEN-1:0]       i_dat_wr,
  input  logic [NREAD*AW-1:0]   i_addr_rd,
  output logic [NREAD*XLEN-1:0] o_dat_rd,
  output logic                  o_ready
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            run_we;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_dat;

  logic [XLEN-1:0] mem [NREGS];

  regs_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_seq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_clr),
    .o_ready    (o_ready),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr)
  );

  // A clear request in RUN drops any same-cycle write.
  assign run_we = o_ready && i_we && !i_clr && (i_addr_wr != ZERO_IDX);

  always_comb begin
    wr_en   = run_we;
    wr_addr = i_addr_wr;
    wr_dat  = i_dat_wr;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_dat  = '0;
    end
  end

  // NOTE: no reset on the array so it maps to distributed RAM; the clear sequencer zeroes it instead.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd_port
    logic [AW-1:0] rd_addr;
    assign rd_addr = i_addr_rd[k*AW +: AW];

    always_comb begin
      if (!o_ready || rd_addr == ZERO_IDX) begin
        o_dat_rd[k*XLEN +: XLEN] = '0;
`ifdef REGS_MULTIPORT_BYPASS_EN
      end else if (run_we && rd_addr == i_addr_wr) begin
        o_dat_rd[k*XLEN +: XLEN] = i_dat_wr;
`endif
      end else begin
        o_dat_rd[k*XLEN +: XLEN] = mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_regs_multiport.sv
// Self-checking bench for regs_multiport (XLEN=32, NREGS=32, NREAD=2) using a
// read-expectation scoreboard fed from a reference model of the array.
module tb_regs_multiport;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr_wr = '0;
  logic [31:0] dat_wr = '0;
  logic [9:0]  addr_rd = '0;
  logic [63:0] dat_rd;
  logic        ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb [$];

  regs_multiport #(
    .XLEN  (32),
    .NREGS (32),
    .NREAD (2)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clr     (clr),
    .i_we      (we),
    .i_addr_wr (addr_wr),
    .i_dat_wr  (dat_wr),
    .i_addr_rd (addr_rd),
    .o_dat_rd  (dat_rd),
    .o_ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  task automatic push_read(input string tag, input logic [4:0] a, input logic [4:0] b,
                           input logic [31:0] ea, input logic [31:0] eb);
    addr_rd = {b, a};
    sb.push_back('{tag: {tag, ".a"}, port: 0, exp: ea});
    sb.push_back('{tag: {tag, ".b"}, port: 1, exp: eb});
  endtask

  task automatic collect();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, dat_rd[e.port*32 +: 32], e.exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    addr_wr = a;
    dat_wr = d;
    @(posedge clk);
    if (a != 5'd0) model[a] = d;
    #1 we = 1'b0;
  endtask

  // Called at a negedge; counts negedges seen with ready low, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    model_clear();

    // Reset release and initial clear.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'b0, ready}, 32'h0);
    rst_n = 1'b1;
    wait_ready(n);
    check("reset_clear_len", n, 32'd31);
    push_read("reset_read", 5'd3, 5'd31, 32'h0, 32'h0);
    collect();

    // Write/read sweep.
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'h00550055 | 32'(i));
    @(negedge clk);
    for (int i = 1; i < 32; i++) begin
      push_read($sformatf("sweep%0d", i), 5'(i), 5'(i - 1),
                model_rd(5'(i)), model_rd(5'(i - 1)));
      collect();
    end

    // x0 protection.
    write_reg(5'd0, 32'hDEADBEEF);
    @(negedge clk);
    push_read("x0", 5'd0, 5'd0, 32'h0, 32'h0);
    collect();

    // Bypass / same-cycle write visibility.
    write_reg(5'd7, 32'h11111111);
    @(negedge clk);
    we = 1'b1;
    addr_wr = 5'd7;
    dat_wr = 32'hA5A5A5A5;
`ifdef REGS_MULTIPORT_BYPASS_EN
    push_read("bypass", 5'd7, 5'd8, 32'hA5A5A5A5, model_rd(5'd8));
`else
    push_read("bypass", 5'd7, 5'd8, 32'h11111111, model_rd(5'd8));
`endif
    collect();
    @(posedge clk);
    model[7] = 32'hA5A5A5A5;
    #1 we = 1'b0;
    @(negedge clk);
    push_read("after_write", 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5);
    collect();

    // Clear beats a simultaneous write.
    @(negedge clk);
    clr = 1'b1;
    we = 1'b1;
    addr_wr = 5'd5;
    dat_wr = 32'h12345678;
    @(negedge clk);
    clr = 1'b0;
    we = 1'b0;
    #1 check("clr_ready_low", {31'b0, ready}, 32'h0);
    push_read("clr_during", 5'd5, 5'd31, 32'h0, 32'h0);
    collect();
    wait_ready(n);
    check("clr_len", n, 32'd31);
    model_clear();
    push_read("clr_after", 5'd5, 5'd9, 32'h0, 32'h0);
    collect();

    // Reset in the middle of a clear.
    write_reg(5'd31, 32'hCAFEF00D);
    write_reg(5'd12, 32'h0BADC0DE);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (9) @(negedge clk);
    push_read("midclr_read", 5'd31, 5'd12, 32'h0, 32'h0);
    collect();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    check("midclr_len", n, 32'd31);
    model_clear();
    push_read("midclr_after", 5'd31, 5'd12, 32'h0, 32'h0);
    collect();

    // Array is usable again after the restarted clear.
    write_reg(5'd12, 32'h87654321);
    @(negedge clk);
    push_read("post_write", 5'd12, 5'd31, model_rd(5'd12), model_rd(5'd31));
    collect();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
